// File: rtl/controlador_memoria_pkg.sv
// -----------------------------------------------------------------------------
// controlador_memoria_pkg
// Shared definitions for the memory controller and its sub-modules:
//   - FSM state encoding (IDLE, WRITE, READ_WAIT, RESP, CLEAR)
//   - default address/data widths for the 512x12 memory
//   - memory port direction constants (MEM_LEER / MEM_ESCRIBIR)
//   - read-wait counter width (enough for READ_LAT up to 4)
// Optional feature macro used by the importing files: CTRL_MEM_CLEAR_EN
// -----------------------------------------------------------------------------
package controlador_memoria_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 12;

    // Memory read/write select levels as seen by memoria4K.
    localparam logic MEM_LEER     = 1'b1;
    localparam logic MEM_ESCRIBIR = 1'b0;

    // Read-wait down-counter width; holds READ_LAT in the range 1..4.
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_RESP      = 3'd3,
        ST_CLEAR     = 3'd4
    } estado_t;

endpackage : controlador_memoria_pkg

// File: rtl/controlador_memoria_barrido.sv
// -----------------------------------------------------------------------------
// controlador_memoria_barrido
// Address sweep used by the post-reset memory clear. Walks the address from 0
// to 2^ADDR_W-1, one step per enabled cycle, and flags the last address.
// Only instantiated when CTRL_MEM_CLEAR_EN is defined.
// Ports:
//   clock   in   1       system clock, posedge
//   reset   in   1       synchronous, active-high; restarts the sweep at 0
//   en      in   1       advance the sweep this cycle
//   dir     out  ADDR_W  address being cleared this cycle
//   fin     out  1       high while the last address is being cleared
// -----------------------------------------------------------------------------
module controlador_memoria_barrido #(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] dir,
    output logic              fin
);

    logic [ADDR_W-1:0] dir_q;
    logic [ADDR_W-1:0] dir_d;

    always_comb begin
        dir_d = dir_q;
        if (en) begin
            dir_d = dir_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_q <= '0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign dir = dir_q;
    assign fin = en && (dir_q == '1);

endmodule : controlador_memoria_barrido

// File: rtl/controlador_memoria.sv
// -----------------------------------------------------------------------------
// controlador_memoria
// Single-outstanding-request controller for a 512x12 synchronous single-port
// memory (memoria4K port set). User requests arrive on a valid/ready
// handshake, are sequenced onto the memory port, and read data is returned on
// a held response handshake.
//
// Optional feature macro: CTRL_MEM_CLEAR_EN
//   defined     -> after reset the FSM sweeps the whole memory writing zeros
//                  (one address per cycle) before accepting requests
//   not defined -> reset goes straight to IDLE, memory untouched
//
// Ports:
//   clock                  in   1       system clock, posedge
//   reset                  in   1       synchronous, active-high
//   req_valid              in   1       user request present
//   req_ready              out  1       request accepted this cycle if valid
//   req_escribir           in   1       1 = write, 0 = read
//   req_direccion          in   ADDR_W  request address
//   req_dato               in   DATA_W  write data
//   resp_valid             out  1       read data available
//   resp_ready             in   1       user consumes read data
//   resp_dato              out  DATA_W  read data, stable while resp_valid
//   leer_escribir_memoria  out  1       memory select: 1 = read, 0 = write
//   direccion_memoria      out  ADDR_W  memory address
//   dato_escribir_memoria  out  DATA_W  memory write data
//   dato_leer_memoria      in   DATA_W  memory read data
//   ocupado                out  1       controller not in IDLE
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a request; memory port parked in read
// WRITE      | one-cycle write strobe on the memory port
// READ_WAIT  | address held on the port, waiting for read data
// RESP       | read data presented, waiting for resp_ready
// CLEAR      | post-reset zero sweep (CTRL_MEM_CLEAR_EN only)
// -----------------------------------------------------------------------------
module controlador_memoria
    import controlador_memoria_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_escribir,
    input  logic [ADDR_W-1:0] req_direccion,
    input  logic [DATA_W-1:0] req_dato,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_dato,
    output logic              leer_escribir_memoria,
    output logic [ADDR_W-1:0] direccion_memoria,
    output logic [DATA_W-1:0] dato_escribir_memoria,
    input  logic [DATA_W-1:0] dato_leer_memoria,
    output logic              ocupado
);

`ifdef CTRL_MEM_CLEAR_EN
    localparam estado_t ESTADO_RESET = ST_CLEAR;
`else
    localparam estado_t ESTADO_RESET = ST_IDLE;
`endif

    estado_t           estado_q,     estado_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              leer_q,       leer_d;
    logic [ADDR_W-1:0] dir_q,        dir_d;
    logic [DATA_W-1:0] dato_q,       dato_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_dato_q,  resp_dato_d;

    logic aceptar;
    logic barrido_fin;

    // Ready is gated by reset so nothing is accepted on a reset cycle even
    // when the state register already sits in IDLE.
    assign req_ready = (estado_q == ST_IDLE) && !reset;
    assign aceptar   = req_valid && req_ready;

`ifdef CTRL_MEM_CLEAR_EN
    logic              barrido_en;
    logic [ADDR_W-1:0] barrido_dir;

    assign barrido_en = (estado_q == ST_CLEAR) && !reset;

    controlador_memoria_barrido #(
        .ADDR_W (ADDR_W)
    ) u_barrido (
        .clock (clock),
        .reset (reset),
        .en    (barrido_en),
        .dir   (barrido_dir),
        .fin   (barrido_fin)
    );

    // During the sweep the port is taken over combinationally so that every
    // CLEAR cycle is a write; the registered port values resume afterwards.
    assign leer_escribir_memoria = barrido_en ? MEM_ESCRIBIR : leer_q;
    assign direccion_memoria     = barrido_en ? barrido_dir  : dir_q;
    assign dato_escribir_memoria = barrido_en ? '0           : dato_q;
`else
    assign barrido_fin           = 1'b0;
    assign leer_escribir_memoria = leer_q;
    assign direccion_memoria     = dir_q;
    assign dato_escribir_memoria = dato_q;
`endif

    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        leer_d       = leer_q;
        dir_d        = dir_q;
        dato_d       = dato_q;
        resp_valid_d = resp_valid_q;
        resp_dato_d  = resp_dato_q;

        case (estado_q)
            ST_IDLE: begin
                if (aceptar) begin
                    dir_d  = req_direccion;
                    dato_d = req_dato;
                    if (req_escribir) begin
                        leer_d   = MEM_ESCRIBIR;
                        estado_d = ST_WRITE;
                    end else begin
                        leer_d   = MEM_LEER;
                        // Address reaches the memory one cycle after accept,
                        // so waiting READ_LAT more cycles after that lands the
                        // capture on settled read data.
                        cnt_d    = CNT_W'(READ_LAT);
                        estado_d = ST_READ_WAIT;
                    end
                end
            end

            ST_WRITE: begin
                leer_d   = MEM_LEER;
                estado_d = ST_IDLE;
            end

            ST_READ_WAIT: begin
                if (cnt_q == '0) begin
                    resp_dato_d  = dato_leer_memoria;
                    resp_valid_d = 1'b1;
                    estado_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    estado_d     = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                if (barrido_fin) begin
                    estado_d = ST_IDLE;
                end
            end

            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ESTADO_RESET;
            cnt_q        <= '0;
            leer_q       <= MEM_LEER;
            dir_q        <= '0;
            dato_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_dato_q  <= '0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            leer_q       <= leer_d;
            dir_q        <= dir_d;
            dato_q       <= dato_d;
            resp_valid_q <= resp_valid_d;
            resp_dato_q  <= resp_dato_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_dato  = resp_dato_q;
    assign ocupado    = (estado_q != ST_IDLE);

endmodule : controlador_memoria
